// File: rtl/odelay_pkg.sv
// odelay_pkg: shared state type and helper functions for the output delay array
package odelay_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } odly_state_t;

    // Widest select vector the helper can produce; callers slice the low NUM_TAPS bits.
    localparam int THERM_MAX = 64;

    // Thermometer code: the lowest 'tap' bits set, never more than num_taps bits.
    function automatic logic [THERM_MAX-1:0] therm_enc(input int tap, input int num_taps);
        logic [THERM_MAX-1:0] r;
        r = '0;
        for (int k = 0; k < THERM_MAX; k++) begin
            r[k] = (k < tap) && (k < num_taps);
        end
        return r;
    endfunction

    // Width of a counter that holds 0..settle_cycles, never narrower than one bit.
    function automatic int settle_w(input int settle_cycles);
        return (settle_cycles > 0) ? $clog2(settle_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/cascade_delays.sv
// cascade_delays: behavioural tap cascade; selected stages pass the line through, others tap the input
module cascade_delays #(
    parameter int NUM_TAPS = 6
) (
    input  logic                data_i,
    input  logic [NUM_TAPS-1:0] select_i,
    output logic                data_o
);

    logic [NUM_TAPS:0] stage_w;

    assign stage_w[0] = data_i;

    // Each enabled stage extends the chain; a disabled stage restarts it from the line input.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_stage
        assign stage_w[k+1] = select_i[k] ? stage_w[k] : data_i;
    end

    assign data_o = stage_w[NUM_TAPS];

endmodule

// File: rtl/odelay_tap_ctrl.sv
// odelay_tap_ctrl: per-channel tap counter, settle FSM and thermometer select; ODELAY_WRAP_EN enables boundary wrap
module odelay_tap_ctrl
    import odelay_pkg::*;
#(
    parameter int NUM_TAPS      = 6,
    parameter int CNT_W         = 9,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_vtc_i,
    input  logic                ce_i,
    input  logic                inc_i,
    input  logic                load_i,
    input  logic [CNT_W-1:0]    cnt_val_i,
    output logic [CNT_W-1:0]    cnt_val_o,
    output logic [NUM_TAPS-1:0] select_o,
    output logic                rdy_o
);

    localparam int TW = $clog2(NUM_TAPS + 1);
    localparam int SW = settle_w(SETTLE_CYCLES);
    localparam logic [TW-1:0]    MAX_T    = TW'(NUM_TAPS);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(NUM_TAPS);
    localparam logic [SW-1:0]    CNT_INIT = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;
    localparam bit               HAS_SETTLE = SETTLE_CYCLES > 0;

    logic [TW-1:0]        tap_q, tap_d;
    logic [SW-1:0]        cnt_q, cnt_d;
    odly_state_t          state_q, state_d;
    logic [CNT_W-1:0]     load_c;
    logic [TW-1:0]        inc_tap, dec_tap, cmd_tap;
    logic                 accept, changed;
    logic [THERM_MAX-1:0] sel_full;

    assign rdy_o     = (state_q == IDLE);
    assign cnt_val_o = CNT_W'(tap_q);
    assign select_o  = sel_full[NUM_TAPS-1:0];

    // Next tap and settle state: LOAD wins over CE, only a real tap change starts settling.
    always_comb begin
        load_c = (cnt_val_i > MAX_C) ? MAX_C : cnt_val_i;
`ifdef ODELAY_WRAP_EN
        inc_tap = (tap_q == MAX_T) ? '0 : tap_q + 1'b1;
        dec_tap = (tap_q == '0) ? MAX_T : tap_q - 1'b1;
`else
        inc_tap = (tap_q == MAX_T) ? MAX_T : tap_q + 1'b1;
        dec_tap = (tap_q == '0) ? '0 : tap_q - 1'b1;
`endif
        cmd_tap = load_i ? load_c[TW-1:0] : (inc_i ? inc_tap : dec_tap);
        accept  = !en_vtc_i && rdy_o && (load_i || ce_i);
        changed = accept && (cmd_tap != tap_q);
        tap_d   = changed ? cmd_tap : tap_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            state_d = (changed && HAS_SETTLE) ? SETTLE : IDLE;
            cnt_d   = (changed && HAS_SETTLE) ? CNT_INIT : cnt_q;
        end else begin
            state_d = (cnt_q == '0) ? IDLE : SETTLE;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        end
    end

    // Select follows the registered tap so it updates together with the count output.
    always_comb begin
        sel_full = therm_enc(int'(tap_q), NUM_TAPS);
    end

    // Tap, settle counter and state registers; reset returns the line to zero delay at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tap_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/odelay_array.sv
// odelay_array: NUM_CH independent output delay lines with settle handshake; ODELAY_WRAP_EN selects wrapping tap steps
module odelay_array
    import odelay_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int NUM_TAPS      = 6,
    parameter int CNT_W         = 9,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN_VTC,
    input  logic [NUM_CH-1:0]       CE,
    input  logic [NUM_CH-1:0]       INC,
    input  logic [NUM_CH-1:0]       LOAD,
    input  logic [CNT_W-1:0]        CNTVALUEIN,
    input  logic [NUM_CH-1:0]       ODATAIN,
    output logic [NUM_CH-1:0]       DATAOUT,
    output logic [NUM_CH*CNT_W-1:0] CNTVALUEOUT,
    output logic [NUM_CH-1:0]       RDY
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [NUM_TAPS-1:0] select_w;

        odelay_tap_ctrl #(
            .NUM_TAPS     (NUM_TAPS),
            .CNT_W        (CNT_W),
            .SETTLE_CYCLES(SETTLE_CYCLES)
        ) u_ctrl (
            .clk_i    (CLK),
            .rst_i    (RST),
            .en_vtc_i (EN_VTC),
            .ce_i     (CE[i]),
            .inc_i    (INC[i]),
            .load_i   (LOAD[i]),
            .cnt_val_i(CNTVALUEIN),
            .cnt_val_o(CNTVALUEOUT[i*CNT_W +: CNT_W]),
            .select_o (select_w),
            .rdy_o    (RDY[i])
        );

        cascade_delays #(
            .NUM_TAPS(NUM_TAPS)
        ) u_cascade (
            .data_i  (ODATAIN[i]),
            .select_i(select_w),
            .data_o  (DATAOUT[i])
        );
    end

endmodule

// File: tb/tb_odelay_array.sv
// tb_odelay_array: directed scoreboard bench for odelay_array
module tb_odelay_array;

    localparam int NCH = 4;
    localparam int NT  = 6;
    localparam int CW  = 9;
    localparam int SC  = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          EN_VTC = 1'b0;
    logic [3:0]    CE = '0;
    logic [3:0]    INC = '0;
    logic [3:0]    LOAD = '0;
    logic [CW-1:0] CNTVALUEIN = '0;
    logic [3:0]    ODATAIN = '0;
    logic [3:0]    DATAOUT;
    logic [35:0]   CNTVALUEOUT;
    logic [3:0]    RDY;

    int total = 0;
    int bad = 0;

    typedef enum int {K_TAP, K_RDY, K_SEL, K_DOUT, K_ALL} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        int          ch;
        logic [35:0] val;
    } exp_t;
    exp_t sb[$];

`ifdef ODELAY_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    odelay_array #(
        .NUM_CH(NCH), .NUM_TAPS(NT), .CNT_W(CW), .SETTLE_CYCLES(SC)
    ) dut (
        .CLK(CLK), .RST(RST), .EN_VTC(EN_VTC), .CE(CE), .INC(INC), .LOAD(LOAD),
        .CNTVALUEIN(CNTVALUEIN), .ODATAIN(ODATAIN), .DATAOUT(DATAOUT),
        .CNTVALUEOUT(CNTVALUEOUT), .RDY(RDY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [35:0] observe(kind_t k, int ch);
        case (k)
            K_TAP:   return 36'(CNTVALUEOUT[ch*CW +: CW]);
            K_RDY:   return 36'(RDY);
            K_SEL:   return 36'(dut.g_ch[0].u_ctrl.select_o);
            K_DOUT:  return 36'(DATAOUT);
            default: return CNTVALUEOUT;
        endcase
    endfunction

    task automatic push(input string tag, input kind_t k, input int ch, input logic [35:0] v);
        sb.push_back('{tag, k, ch, v});
    endtask

    task automatic check();
        exp_t e;
        logic [35:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.kind, e.ch);
            total++;
            assert (o === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        CE = '0;
        LOAD = '0;
    endtask

    initial begin
        // reset state and zero-tap data path while reset is held
        #2;
        ODATAIN = 4'b1010;
        #1;
        push("rst_rdy", K_RDY, 0, 36'hF);
        push("rst_cnt", K_ALL, 0, 36'h0);
        push("rst_dout", K_DOUT, 0, 36'hA);
        check();
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // six accepted increments on channel 0, each followed by two busy cycles
        for (int i = 1; i <= 6; i++) begin
            CE = 4'b0001;
            INC = 4'b0001;
            tick();
            push($sformatf("inc%0d_tap", i), K_TAP, 0, 36'(i));
            push($sformatf("inc%0d_rdy_a", i), K_RDY, 0, 36'hE);
            check();
            tick();
            push($sformatf("inc%0d_rdy_b", i), K_RDY, 0, 36'hE);
            check();
            tick();
            push($sformatf("inc%0d_rdy_c", i), K_RDY, 0, 36'hF);
            check();
        end
        push("sel_full", K_SEL, 0, 36'h3F);
        push("dout_full", K_DOUT, 0, 36'hA);
        check();

        // increment at the top boundary
        CE = 4'b0001;
        INC = 4'b0001;
        tick();
        push("top_tap", K_TAP, 0, WRAP ? 36'h0 : 36'h6);
        push("top_rdy", K_RDY, 0, WRAP ? 36'hE : 36'hF);
        check();
        tick();
        tick();
        push("top_rdy_back", K_RDY, 0, 36'hF);
        check();

        // load channel 0, then step it while busy and step channel 1 in the same cycle
        CNTVALUEIN = 9'd3;
        LOAD = 4'b0001;
        tick();
        push("ld3_tap", K_TAP, 0, 36'h3);
        push("ld3_rdy", K_RDY, 0, 36'hE);
        check();
        CE = 4'b0011;
        INC = 4'b0011;
        tick();
        push("drop_tap0", K_TAP, 0, 36'h3);
        push("step_tap1", K_TAP, 1, 36'h1);
        push("drop_rdy", K_RDY, 0, 36'hC);
        check();
        tick();
        push("drop_rdy2", K_RDY, 0, 36'hD);
        check();
        tick();
        push("drop_rdy3", K_RDY, 0, 36'hF);
        check();

        // LOAD and CE together with an out-of-range value: clamp, CE ignored
        CNTVALUEIN = 9'd9;
        LOAD = 4'b0100;
        CE = 4'b0100;
        INC = 4'b0000;
        tick();
        push("clamp_tap2", K_TAP, 2, 36'h6);
        push("clamp_rdy", K_RDY, 0, 36'hB);
        check();
        tick();
        tick();
        // reloading the current value is a no-op
        LOAD = 4'b0100;
        tick();
        push("same_tap2", K_TAP, 2, 36'h6);
        push("same_rdy", K_RDY, 0, 36'hF);
        check();

        // decrement at the bottom boundary on channel 3
        CE = 4'b1000;
        INC = 4'b0000;
        tick();
        push("bot_tap3", K_TAP, 3, WRAP ? 36'h6 : 36'h0);
        push("bot_rdy", K_RDY, 0, WRAP ? 36'h7 : 36'hF);
        check();
        tick();
        tick();
        push("bot_rdy_back", K_RDY, 0, 36'hF);
        check();

        // EN_VTC blocks every command on every channel
        EN_VTC = 1'b1;
        CE = 4'b1111;
        INC = 4'b1111;
        LOAD = 4'b1111;
        CNTVALUEIN = 9'd2;
        tick();
        push("vtc_tap0", K_TAP, 0, 36'h3);
        push("vtc_tap1", K_TAP, 1, 36'h1);
        push("vtc_tap2", K_TAP, 2, 36'h6);
        push("vtc_tap3", K_TAP, 3, WRAP ? 36'h6 : 36'h0);
        push("vtc_rdy", K_RDY, 0, 36'hF);
        check();
        EN_VTC = 1'b0;

        // EN_VTC rising mid-settle does not stop the countdown
        CE = 4'b0010;
        INC = 4'b0010;
        tick();
        push("vtcs_tap1", K_TAP, 1, 36'h2);
        push("vtcs_rdy", K_RDY, 0, 36'hD);
        check();
        EN_VTC = 1'b1;
        tick();
        push("vtcs_rdy2", K_RDY, 0, 36'hD);
        check();
        tick();
        push("vtcs_rdy3", K_RDY, 0, 36'hF);
        check();
        EN_VTC = 1'b0;

        // asynchronous reset one cycle into settle
        CE = 4'b0001;
        INC = 4'b0001;
        tick();
        push("pre_rst_tap0", K_TAP, 0, 36'h4);
        push("pre_rst_rdy", K_RDY, 0, 36'hE);
        check();
        tick();
        ODATAIN = 4'b0101;
        #1;
        RST = 1'b1;
        #1;
        push("arst_rdy", K_RDY, 0, 36'hF);
        push("arst_cnt", K_ALL, 0, 36'h0);
        push("arst_sel", K_SEL, 0, 36'h0);
        push("arst_dout", K_DOUT, 0, 36'h5);
        check();
        @(negedge CLK);
        RST = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
